// File: rtl/ch0re_idecode_unit.sv
// ch0re_idecode_unit: RV64I ID-stage decoder with load-use stall detection.
// Define CH0RE_IDEC_OUT_REG_EN to register all outputs (1-cycle latency, sync reset to NOP).
package ch0re_idecode_pkg;
    typedef enum logic [2:0] {
        IFORMAT_R, IFORMAT_I, IFORMAT_S, IFORMAT_B, IFORMAT_U, IFORMAT_J, IFORMAT_ILLEGAL
    } iformat_e;

    typedef enum logic [3:0] {
        LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU,
        LSU_SB, LSU_SH, LSU_SW, LSU_SD
    } lsu_op_e;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_op_e;

    typedef enum logic [1:0] {ALU_MUX1_REG, ALU_MUX1_PC, ALU_MUX1_IMM_ZERO} alu_mux1_sel_e;
    typedef enum logic [1:0] {ALU_MUX2_REG, ALU_MUX2_IMM, ALU_MUX2_IMM_FOUR} alu_mux2_sel_e;
endpackage

module ch0re_idecode_unit
    import ch0re_idecode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_instr,
    input  iformat_e      i_ex_iformat,
    input  lsu_op_e       i_ex_lsu_op,
    input  logic          i_ex_wen,
    input  logic [4:0]    i_ex_rd,
    output logic          o_illegal_instr,
    output logic          o_pl_stall,
    output logic          o_wen,
    output logic [4:0]    o_rf_raddr1,
    output logic [4:0]    o_rf_raddr2,
    output logic [4:0]    o_rf_waddr,
    output iformat_e      o_instr_format,
    output alu_op_e       o_alu_op,
    output lsu_op_e       o_lsu_op,
    output logic [XLEN-1:0] o_imm,
    output alu_mux1_sel_e o_alu_mux1_sel,
    output alu_mux2_sel_e o_alu_mux2_sel
);
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign rd     = i_instr[11:7];

    function automatic alu_op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    iformat_e        dec_fmt;
    alu_op_e         dec_alu;
    lsu_op_e         dec_lsu;
    alu_mux1_sel_e   dec_m1;
    alu_mux2_sel_e   dec_m2;
    logic            dec_wen;
    logic            legal;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        legal   = 1'b1;
        dec_fmt = IFORMAT_ILLEGAL;
        dec_alu = ALU_ADD;
        dec_lsu = LSU_NONE;
        dec_m1  = ALU_MUX1_REG;
        dec_m2  = ALU_MUX2_REG;
        dec_wen = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_fmt = IFORMAT_R;
                if (funct7 == F7_BASE)
                    dec_alu = base_op(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000)
                    dec_alu = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    dec_alu = ALU_SRA;
                else
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                dec_fmt = IFORMAT_I;
                dec_m2  = ALU_MUX2_IMM;
                dec_alu = base_op(funct3);
                // 64-bit shifts use a 6-bit shamt, so only instr[31:26] selects the variant
                if (funct3 == 3'b001)
                    legal = (i_instr[31:26] == 6'b000000);
                else if (funct3 == 3'b101) begin
                    if (i_instr[31:26] == 6'b010000)
                        dec_alu = ALU_SRA;
                    else if (i_instr[31:26] != 6'b000000)
                        legal = 1'b0;
                end
            end
            OPC_OP_32: begin
                dec_fmt = IFORMAT_R;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_alu = ALU_ADDW;
                    {F7_ALT,  3'b000}: dec_alu = ALU_SUBW;
                    {F7_BASE, 3'b001}: dec_alu = ALU_SLLW;
                    {F7_BASE, 3'b101}: dec_alu = ALU_SRLW;
                    {F7_ALT,  3'b101}: dec_alu = ALU_SRAW;
                    default:           legal   = 1'b0;
                endcase
            end
            OPC_OP_IMM_32: begin
                dec_fmt = IFORMAT_I;
                dec_m2  = ALU_MUX2_IMM;
                case (funct3)
                    3'b000: dec_alu = ALU_ADDW;
                    3'b001: begin
                        dec_alu = ALU_SLLW;
                        legal   = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)
                            dec_alu = ALU_SRLW;
                        else if (funct7 == F7_ALT)
                            dec_alu = ALU_SRAW;
                        else
                            legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_fmt = IFORMAT_I;
                dec_m2  = ALU_MUX2_IMM;
                case (funct3)
                    3'b000:  dec_lsu = LSU_LB;
                    3'b001:  dec_lsu = LSU_LH;
                    3'b010:  dec_lsu = LSU_LW;
                    3'b011:  dec_lsu = LSU_LD;
                    3'b100:  dec_lsu = LSU_LBU;
                    3'b101:  dec_lsu = LSU_LHU;
                    3'b110:  dec_lsu = LSU_LWU;
                    default: legal   = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec_fmt = IFORMAT_S;
                dec_m2  = ALU_MUX2_IMM;
                case (funct3)
                    3'b000:  dec_lsu = LSU_SB;
                    3'b001:  dec_lsu = LSU_SH;
                    3'b010:  dec_lsu = LSU_SW;
                    3'b011:  dec_lsu = LSU_SD;
                    default: legal   = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                dec_fmt = IFORMAT_B;
                dec_wen = 1'b0;
                case (funct3)
                    3'b000:  dec_alu = ALU_BEQ;
                    3'b001:  dec_alu = ALU_BNE;
                    3'b100:  dec_alu = ALU_BLT;
                    3'b101:  dec_alu = ALU_BGE;
                    3'b110:  dec_alu = ALU_BLTU;
                    3'b111:  dec_alu = ALU_BGEU;
                    default: legal   = 1'b0;
                endcase
            end
            OPC_JALR: begin
                dec_fmt = IFORMAT_I;
                dec_m1  = ALU_MUX1_PC;
                dec_m2  = ALU_MUX2_IMM_FOUR;
                legal   = (funct3 == 3'b000);
            end
            OPC_JAL: begin
                dec_fmt = IFORMAT_J;
                dec_m1  = ALU_MUX1_PC;
                dec_m2  = ALU_MUX2_IMM_FOUR;
            end
            OPC_LUI: begin
                dec_fmt = IFORMAT_U;
                dec_m1  = ALU_MUX1_IMM_ZERO;
                dec_m2  = ALU_MUX2_IMM;
            end
            OPC_AUIPC: begin
                dec_fmt = IFORMAT_U;
                dec_m1  = ALU_MUX1_PC;
                dec_m2  = ALU_MUX2_IMM;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec_fmt = IFORMAT_ILLEGAL;
            dec_alu = ALU_ADD;
            dec_lsu = LSU_NONE;
            dec_m1  = ALU_MUX1_REG;
            dec_m2  = ALU_MUX2_REG;
            dec_wen = 1'b0;
        end
    end

    always_comb begin
        case (dec_fmt)
            IFORMAT_I: dec_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            IFORMAT_S: dec_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IFORMAT_B: dec_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                                  i_instr[30:25], i_instr[11:8], 1'b0};
            IFORMAT_U: dec_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
            IFORMAT_J: dec_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                                  i_instr[20], i_instr[30:21], 1'b0};
            default:   dec_imm = '0;
        endcase
    end

    logic ex_is_load;
    logic use_rs1;
    logic use_rs2;
    logic dec_stall;

    assign ex_is_load = (i_ex_iformat == IFORMAT_I) &&
                        (i_ex_lsu_op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU});
    assign use_rs1    = dec_fmt inside {IFORMAT_R, IFORMAT_I, IFORMAT_S, IFORMAT_B};
    assign use_rs2    = dec_fmt inside {IFORMAT_R, IFORMAT_S, IFORMAT_B};
    // Illegal decodes report no source usage, so they can never stall.
    assign dec_stall  = ex_is_load && i_ex_wen && (i_ex_rd != 5'd0) &&
                        ((use_rs1 && (i_ex_rd == rs1)) || (use_rs2 && (i_ex_rd == rs2)));

`ifdef CH0RE_IDEC_OUT_REG_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_illegal_instr <= 1'b0;
            o_pl_stall      <= 1'b0;
            o_wen           <= 1'b0;
            o_rf_raddr1     <= '0;
            o_rf_raddr2     <= '0;
            o_rf_waddr      <= '0;
            o_instr_format  <= IFORMAT_I;
            o_alu_op        <= ALU_ADD;
            o_lsu_op        <= LSU_NONE;
            o_imm           <= '0;
            o_alu_mux1_sel  <= ALU_MUX1_REG;
            o_alu_mux2_sel  <= ALU_MUX2_IMM;
        end else begin
            o_illegal_instr <= !legal;
            o_pl_stall      <= dec_stall;
            o_wen           <= dec_wen && !dec_stall;
            o_rf_raddr1     <= rs1;
            o_rf_raddr2     <= rs2;
            o_rf_waddr      <= rd;
            o_instr_format  <= dec_fmt;
            o_alu_op        <= dec_alu;
            o_lsu_op        <= dec_stall ? LSU_NONE : dec_lsu;
            o_imm           <= dec_imm;
            o_alu_mux1_sel  <= dec_m1;
            o_alu_mux2_sel  <= dec_m2;
        end
    end
`else
    assign o_illegal_instr = !legal;
    assign o_pl_stall      = dec_stall;
    assign o_wen           = dec_wen && !dec_stall;
    assign o_rf_raddr1     = rs1;
    assign o_rf_raddr2     = rs2;
    assign o_rf_waddr      = rd;
    assign o_instr_format  = dec_fmt;
    assign o_alu_op        = dec_alu;
    assign o_lsu_op        = dec_stall ? LSU_NONE : dec_lsu;
    assign o_imm           = dec_imm;
    assign o_alu_mux1_sel  = dec_m1;
    assign o_alu_mux2_sel  = dec_m2;

    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst_n;
`endif
endmodule

// File: tb/tb_ch0re_idecode_unit.sv
// Bench for ch0re_idecode_unit: mask/match instruction table model, random stimulus, literal anchors.
// Follows CH0RE_IDEC_OUT_REG_EN to expect either zero or one cycle of latency.
module tb_ch0re_idecode_unit;
    import ch0re_idecode_pkg::*;

    typedef struct packed {
        logic          illegal;
        logic          stall;
        logic          wen;
        logic [4:0]    ra1;
        logic [4:0]    ra2;
        logic [4:0]    wa;
        iformat_e      fmt;
        alu_op_e       alu;
        lsu_op_e       lsu;
        logic [63:0]   imm;
        alu_mux1_sel_e m1;
        alu_mux2_sel_e m2;
    } dec_t;

    typedef struct packed {
        logic [31:0]   mask;
        logic [31:0]   match;
        iformat_e      fmt;
        alu_op_e       alu;
        lsu_op_e       lsu;
        alu_mux1_sel_e m1;
        alu_mux2_sel_e m2;
        logic          wen;
    } entry_t;

    localparam logic [31:0] MR  = 32'hFE00707F;
    localparam logic [31:0] MI  = 32'h0000707F;
    localparam logic [31:0] MO  = 32'h0000007F;
    localparam logic [31:0] MS6 = 32'hFC00707F;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] instr;
    iformat_e ex_fmt;
    lsu_op_e ex_lsu;
    logic ex_wen;
    logic [4:0] ex_rd;

    logic illegal, stall, wen;
    logic [4:0] ra1, ra2, wa;
    iformat_e fmt;
    alu_op_e alu;
    lsu_op_e lsu;
    logic [63:0] imm;
    alu_mux1_sel_e m1;
    alu_mux2_sel_e m2;

    int n_cmp = 0;
    int n_err = 0;
    logic check_en = 1'b0;
    entry_t tbl[$];
    dec_t exp_q;

    always #5 clk = ~clk;

    ch0re_idecode_unit #(.XLEN(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr),
        .i_ex_iformat(ex_fmt), .i_ex_lsu_op(ex_lsu), .i_ex_wen(ex_wen), .i_ex_rd(ex_rd),
        .o_illegal_instr(illegal), .o_pl_stall(stall), .o_wen(wen),
        .o_rf_raddr1(ra1), .o_rf_raddr2(ra2), .o_rf_waddr(wa),
        .o_instr_format(fmt), .o_alu_op(alu), .o_lsu_op(lsu), .o_imm(imm),
        .o_alu_mux1_sel(m1), .o_alu_mux2_sel(m2)
    );

    function automatic dec_t mk(input logic il, input logic st, input logic w,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] aw,
                                input iformat_e f, input alu_op_e a, input lsu_op_e l,
                                input logic [63:0] im, input alu_mux1_sel_e s1, input alu_mux2_sel_e s2);
        dec_t d;
        d.illegal = il; d.stall = st; d.wen = w;
        d.ra1 = a1; d.ra2 = a2; d.wa = aw;
        d.fmt = f; d.alu = a; d.lsu = l; d.imm = im; d.m1 = s1; d.m2 = s2;
        return d;
    endfunction

    function automatic dec_t dut_now();
        return mk(illegal, stall, wen, ra1, ra2, wa, fmt, alu, lsu, imm, m1, m2);
    endfunction

    task automatic add(input logic [31:0] mk_, input logic [31:0] mt, input iformat_e f, input alu_op_e a,
                       input lsu_op_e l, input alu_mux1_sel_e s1, input alu_mux2_sel_e s2, input logic w);
        entry_t e;
        e.mask = mk_; e.match = mt; e.fmt = f; e.alu = a; e.lsu = l; e.m1 = s1; e.m2 = s2; e.wen = w;
        tbl.push_back(e);
    endtask

    task automatic add_r(input logic [31:0] mt, input alu_op_e a);
        add(MR, mt, IFORMAT_R, a, LSU_NONE, ALU_MUX1_REG, ALU_MUX2_REG, 1'b1);
    endtask
    task automatic add_i(input logic [31:0] mk_, input logic [31:0] mt, input alu_op_e a, input lsu_op_e l);
        add(mk_, mt, IFORMAT_I, a, l, ALU_MUX1_REG, ALU_MUX2_IMM, 1'b1);
    endtask
    task automatic add_s(input logic [31:0] mt, input lsu_op_e l);
        add(MI, mt, IFORMAT_S, ALU_ADD, l, ALU_MUX1_REG, ALU_MUX2_IMM, 1'b1);
    endtask
    task automatic add_b(input logic [31:0] mt, input alu_op_e a);
        add(MI, mt, IFORMAT_B, a, LSU_NONE, ALU_MUX1_REG, ALU_MUX2_REG, 1'b0);
    endtask

    // RV64I encodings written as disassembler-style mask/match pairs.
    task automatic build_table();
        add(MO, 32'h00000037, IFORMAT_U, ALU_ADD, LSU_NONE, ALU_MUX1_IMM_ZERO, ALU_MUX2_IMM, 1'b1);
        add(MO, 32'h00000017, IFORMAT_U, ALU_ADD, LSU_NONE, ALU_MUX1_PC, ALU_MUX2_IMM, 1'b1);
        add(MO, 32'h0000006F, IFORMAT_J, ALU_ADD, LSU_NONE, ALU_MUX1_PC, ALU_MUX2_IMM_FOUR, 1'b1);
        add(MI, 32'h00000067, IFORMAT_I, ALU_ADD, LSU_NONE, ALU_MUX1_PC, ALU_MUX2_IMM_FOUR, 1'b1);
        add_b(32'h00000063, ALU_BEQ);  add_b(32'h00001063, ALU_BNE);  add_b(32'h00004063, ALU_BLT);
        add_b(32'h00005063, ALU_BGE);  add_b(32'h00006063, ALU_BLTU); add_b(32'h00007063, ALU_BGEU);
        add_i(MI, 32'h00000003, ALU_ADD, LSU_LB);  add_i(MI, 32'h00001003, ALU_ADD, LSU_LH);
        add_i(MI, 32'h00002003, ALU_ADD, LSU_LW);  add_i(MI, 32'h00003003, ALU_ADD, LSU_LD);
        add_i(MI, 32'h00004003, ALU_ADD, LSU_LBU); add_i(MI, 32'h00005003, ALU_ADD, LSU_LHU);
        add_i(MI, 32'h00006003, ALU_ADD, LSU_LWU);
        add_s(32'h00000023, LSU_SB); add_s(32'h00001023, LSU_SH);
        add_s(32'h00002023, LSU_SW); add_s(32'h00003023, LSU_SD);
        add_i(MI, 32'h00000013, ALU_ADD, LSU_NONE);  add_i(MI, 32'h00002013, ALU_SLT, LSU_NONE);
        add_i(MI, 32'h00003013, ALU_SLTU, LSU_NONE); add_i(MI, 32'h00004013, ALU_XOR, LSU_NONE);
        add_i(MI, 32'h00006013, ALU_OR, LSU_NONE);   add_i(MI, 32'h00007013, ALU_AND, LSU_NONE);
        add_i(MS6, 32'h00001013, ALU_SLL, LSU_NONE); add_i(MS6, 32'h00005013, ALU_SRL, LSU_NONE);
        add_i(MS6, 32'h40005013, ALU_SRA, LSU_NONE);
        add_i(MI, 32'h0000001B, ALU_ADDW, LSU_NONE); add_i(MR, 32'h0000101B, ALU_SLLW, LSU_NONE);
        add_i(MR, 32'h0000501B, ALU_SRLW, LSU_NONE); add_i(MR, 32'h4000501B, ALU_SRAW, LSU_NONE);
        add_r(32'h00000033, ALU_ADD); add_r(32'h40000033, ALU_SUB); add_r(32'h00001033, ALU_SLL);
        add_r(32'h00002033, ALU_SLT); add_r(32'h00003033, ALU_SLTU); add_r(32'h00004033, ALU_XOR);
        add_r(32'h00005033, ALU_SRL); add_r(32'h40005033, ALU_SRA); add_r(32'h00006033, ALU_OR);
        add_r(32'h00007033, ALU_AND);
        add_r(32'h0000003B, ALU_ADDW); add_r(32'h4000003B, ALU_SUBW); add_r(32'h0000103B, ALU_SLLW);
        add_r(32'h0000503B, ALU_SRLW); add_r(32'h4000503B, ALU_SRAW);
    endtask

    function automatic dec_t model(input logic [31:0] ins, input iformat_e ef, input lsu_op_e el,
                                   input logic ew, input logic [4:0] erd);
        dec_t d;
        int hit;
        int si;
        longint sx;
        logic ex_load, rd1, rd2;
        hit = -1;
        foreach (tbl[k]) if (hit < 0 && (ins & tbl[k].mask) == tbl[k].match) hit = k;
        d = mk(1'b1, 1'b0, 1'b0, ins[19:15], ins[24:20], ins[11:7], IFORMAT_ILLEGAL, ALU_ADD, LSU_NONE,
               64'd0, ALU_MUX1_REG, ALU_MUX2_REG);
        if (hit < 0) return d;
        d.illegal = 1'b0;
        d.fmt = tbl[hit].fmt; d.alu = tbl[hit].alu; d.lsu = tbl[hit].lsu;
        d.m1 = tbl[hit].m1; d.m2 = tbl[hit].m2; d.wen = tbl[hit].wen;
        si = ins;
        sx = si;
        case (d.fmt)
            IFORMAT_I: d.imm = sx >>> 20;
            IFORMAT_S: d.imm = ((sx >>> 25) << 5) | longint'(ins[11:7]);
            IFORMAT_B: d.imm = ((sx >>> 31) << 12) | (longint'(ins[7]) << 11) |
                               (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            IFORMAT_U: d.imm = (sx >>> 12) << 12;
            IFORMAT_J: d.imm = ((sx >>> 31) << 20) | (longint'(ins[19:12]) << 12) |
                               (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            default:   d.imm = 64'd0;
        endcase
        ex_load = (ef == IFORMAT_I) && (el inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU});
        rd1 = d.fmt inside {IFORMAT_R, IFORMAT_I, IFORMAT_S, IFORMAT_B};
        rd2 = d.fmt inside {IFORMAT_R, IFORMAT_S, IFORMAT_B};
        d.stall = ex_load && ew && (erd != 5'd0) &&
                  ((rd1 && erd == ins[19:15]) || (rd2 && erd == ins[24:20]));
        if (d.stall) begin
            d.wen = 1'b0;
            d.lsu = LSU_NONE;
        end
        return d;
    endfunction

    always @(posedge clk)
        exp_q <= rst_n ? model(instr, ex_fmt, ex_lsu, ex_wen, ex_rd)
                       : mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, IFORMAT_I, ALU_ADD, LSU_NONE, 64'd0,
                            ALU_MUX1_REG, ALU_MUX2_IMM);

    always @(negedge clk) begin
        dec_t e;
`ifdef CH0RE_IDEC_OUT_REG_EN
        e = exp_q;
`else
        e = model(instr, ex_fmt, ex_lsu, ex_wen, ex_rd);
`endif
        if (check_en) begin
            n_cmp++;
            if (dut_now() !== e) begin
                n_err++;
                $display("FAIL decode instr=%h ex_rd=%0d got=%h want=%h", instr, ex_rd, dut_now(), e);
            end
        end
    end

    task automatic settle();
`ifdef CH0RE_IDEC_OUT_REG_EN
        @(posedge clk);
`endif
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] ins, input iformat_e ef, input lsu_op_e el,
                       input logic ew, input logic [4:0] erd, input dec_t want);
        dec_t m;
        @(posedge clk);
        #1;
        instr = ins; ex_fmt = ef; ex_lsu = el; ex_wen = ew; ex_rd = erd;
        settle();
        m = model(ins, ef, el, ew, erd);
        n_cmp++;
        if (m !== want) begin
            n_err++;
            $display("FAIL model_%s got=%h want=%h", nm, m, want);
        end
        n_cmp++;
        if (dut_now() !== want) begin
            n_err++;
            $display("FAIL dut_%s got=%h want=%h", nm, dut_now(), want);
        end
    endtask

    initial begin
        logic [31:0] rnd;
        logic [6:0] opcs[13];
        int k;
        opcs = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0F};
        rst_n = 1'b0; instr = 32'h00000013;
        ex_fmt = IFORMAT_ILLEGAL; ex_lsu = LSU_NONE; ex_wen = 1'b0; ex_rd = 5'd0;
        build_table();
        @(posedge clk);
        #1 check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        lit("add", 32'h002081B3, IFORMAT_R, LSU_NONE, 1'b0, 5'd0,
            mk(0, 0, 1, 5'd1, 5'd2, 5'd3, IFORMAT_R, ALU_ADD, LSU_NONE, 64'd0, ALU_MUX1_REG, ALU_MUX2_REG));
        lit("jalr", 32'h000280E7, IFORMAT_R, LSU_NONE, 1'b0, 5'd0,
            mk(0, 0, 1, 5'd5, 5'd0, 5'd1, IFORMAT_I, ALU_ADD, LSU_NONE, 64'd0, ALU_MUX1_PC, ALU_MUX2_IMM_FOUR));
        lit("lui", 32'h123452B7, IFORMAT_R, LSU_NONE, 1'b0, 5'd0,
            mk(0, 0, 1, 5'd8, 5'd3, 5'd5, IFORMAT_U, ALU_ADD, LSU_NONE, 64'h0000000012345000,
               ALU_MUX1_IMM_ZERO, ALU_MUX2_IMM));
        lit("beq", 32'hFE208EE3, IFORMAT_R, LSU_NONE, 1'b0, 5'd0,
            mk(0, 0, 0, 5'd1, 5'd2, 5'd29, IFORMAT_B, ALU_BEQ, LSU_NONE, 64'hFFFFFFFFFFFFFFFC,
               ALU_MUX1_REG, ALU_MUX2_REG));
        lit("zero", 32'h00000000, IFORMAT_R, LSU_NONE, 1'b0, 5'd0,
            mk(1, 0, 0, 5'd0, 5'd0, 5'd0, IFORMAT_ILLEGAL, ALU_ADD, LSU_NONE, 64'd0, ALU_MUX1_REG, ALU_MUX2_REG));
        lit("stall_rs1", 32'h002081B3, IFORMAT_I, LSU_LD, 1'b1, 5'd1,
            mk(0, 1, 0, 5'd1, 5'd2, 5'd3, IFORMAT_R, ALU_ADD, LSU_NONE, 64'd0, ALU_MUX1_REG, ALU_MUX2_REG));
        lit("no_stall_x0", 32'h002081B3, IFORMAT_I, LSU_LD, 1'b1, 5'd0,
            mk(0, 0, 1, 5'd1, 5'd2, 5'd3, IFORMAT_R, ALU_ADD, LSU_NONE, 64'd0, ALU_MUX1_REG, ALU_MUX2_REG));
        lit("ld", 32'h00833283, IFORMAT_R, LSU_NONE, 1'b0, 5'd0,
            mk(0, 0, 1, 5'd6, 5'd8, 5'd5, IFORMAT_I, ALU_ADD, LSU_LD, 64'd8, ALU_MUX1_REG, ALU_MUX2_IMM));
        lit("sd_stall_rs2", 32'h0020B823, IFORMAT_I, LSU_LW, 1'b1, 5'd2,
            mk(0, 1, 0, 5'd1, 5'd2, 5'd16, IFORMAT_S, ALU_ADD, LSU_NONE, 64'd16, ALU_MUX1_REG, ALU_MUX2_IMM));
        lit("srai_bad", 32'h60005013, IFORMAT_R, LSU_NONE, 1'b0, 5'd0,
            mk(1, 0, 0, 5'd0, 5'd0, 5'd0, IFORMAT_ILLEGAL, ALU_ADD, LSU_NONE, 64'd0, ALU_MUX1_REG, ALU_MUX2_REG));

        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            rnd = $urandom;
            k = $urandom_range(0, 9);
            if (k < 7) begin
                k = $urandom_range(0, tbl.size() - 1);
                instr = tbl[k].match | (rnd & ~tbl[k].mask);
            end else if (k < 9) begin
                instr = {rnd[31:7], opcs[$urandom_range(0, 12)]};
            end else begin
                instr = rnd;
            end
            ex_fmt = ($urandom_range(0, 1) == 1) ? IFORMAT_I : iformat_e'($urandom_range(0, 6));
            ex_lsu = ($urandom_range(0, 1) == 1) ? lsu_op_e'($urandom_range(1, 7)) : lsu_op_e'($urandom_range(0, 11));
            ex_wen = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 2);
            ex_rd = (k == 0) ? instr[19:15] : (k == 1) ? instr[24:20] : 5'($urandom_range(0, 31));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ch0re_idecode_unit.md
Name: ch0re_idecode_unit

Overview:
- RV64I instruction decoder for the ch0re 5-stage pipeline, located in the ID stage.
- Splits the 32-bit fetched word into register-file addresses, a sign-extended 64-bit immediate, ALU operation and ALU operand-mux selects, format class, LSU op and write enable.
- Flags illegal encodings.
- Detects load-use hazards against the instruction currently in EX and raises a pipeline stall.

Parameters:
- XLEN, 64, datapath and immediate width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_instr  in  32  instruction word from IF/ID.
- i_ex_iformat  in  iformat_e  format of the instruction in EX.
- i_ex_lsu_op  in  lsu_op_e  LSU op of the instruction in EX.
- i_ex_wen  in  1  EX instruction writes the register file.
- i_ex_rd  in  5  EX destination register.
- o_illegal_instr  out  1  encoding not in supported RV64I set.
- o_pl_stall  out  1  load-use stall request.
- o_wen  out  1  write enable.
- o_rf_raddr1  out  5  rs1 address = i_instr[19:15].
- o_rf_raddr2  out  5  rs2 address = i_instr[24:20].
- o_rf_waddr  out  5  rd address = i_instr[11:7].
- o_instr_format  out  iformat_e  one of IFORMAT_R/I/S/B/U/J/ILLEGAL.
- o_alu_op  out  alu_op_e  ALU operation.
- o_lsu_op  out  lsu_op_e  LSU operation (LSU_NONE for non-memory instructions).
- o_imm  out  XLEN  sign-extended immediate.
- o_alu_mux1_sel  out  alu_mux1_sel_e  one of REG/PC/IMM_ZERO.
- o_alu_mux2_sel  out  alu_mux2_sel_e  one of REG/IMM/IMM_FOUR.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (i_clk, i_rst_n).
- Base build is purely combinational, zero latency. i_clk/i_rst_n are used only by the optional feature.
- Register address fields are always driven from their fixed bit positions, regardless of format.

Format and control per opcode:
- OP (0110011) and OP-32 (0111011): IFORMAT_R; mux1 REG, mux2 REG; wen=1.
- OP-IMM, OP-IMM-32, LOAD (0000011): IFORMAT_I; mux1 REG, mux2 IMM; wen=1.
- JALR (1100111, funct3=0): IFORMAT_I; mux1 PC, mux2 IMM_FOUR (link value PC+4); wen=1.
- STORE (0100011): IFORMAT_S; mux1 REG, mux2 IMM; wen=1. Store vs. register write is distinguished downstream by o_lsu_op.
- BRANCH (1100011): IFORMAT_B; mux1 REG, mux2 REG; wen=0.
- JAL (1101111): IFORMAT_J; mux1 PC, mux2 IMM_FOUR; wen=1.
- LUI (0110111): IFORMAT_U; mux1 IMM_ZERO, mux2 IMM; wen=1.
- AUIPC (0010111): IFORMAT_U; mux1 PC, mux2 IMM; wen=1.

Immediates (all sign-extended from instr[31] to XLEN):
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R: o_imm=0.

ALU op selection:
- OP/OP-IMM: from funct3/funct7 → ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- OP-32/OP-IMM-32: W variants → ADDW, SUBW, SLLW, SRLW, SRAW.
- Loads, stores, JAL, JALR, LUI, AUIPC: ADD.
- Branches: the compare op per funct3 → BEQ, BNE, BLT, BGE, BLTU, BGEU.

Legality rules:
- 64-bit shifts: shamt is instr[25:20]; instr[31:26] must be 000000 (logical) or 010000 (SRA).
- W shifts: instr[25] must be 0.
- Any other unlisted funct3/funct7 combination is illegal.

Illegal encodings, including SYSTEM, MISC-MEM and all-zero:
- Drive IFORMAT_ILLEGAL, o_illegal_instr=1, o_wen=0.
- Drive o_lsu_op=LSU_NONE, ALU op ADD, mux1 REG, mux2 REG, o_imm=0, o_pl_stall=0.

Load-use stall:
- o_pl_stall=1 when all of the following hold:
  - i_ex_lsu_op is a load and i_ex_iformat==IFORMAT_I;
  - i_ex_wen=1 and i_ex_rd!=0;
  - i_ex_rd equals a source register actually used by the current instruction: rs1 for R/I/S/B, rs2 for R/S/B.
- Otherwise o_pl_stall=0.
- While o_pl_stall=1: o_wen=0 and o_lsu_op=LSU_NONE (bubble). All other outputs still reflect the decode.

Optional Feature:
- Macro: CH0RE_IDEC_OUT_REG_EN.
- Defined: all outputs are registered on the rising edge of i_clk, giving 1-cycle latency. While i_rst_n=0 at an edge, the registers load the NOP decode (addi x0,x0,0): IFORMAT_I, ADD, wen=0, illegal=0, stall=0, addresses 0, imm 0, mux1 REG, mux2 IMM, LSU_NONE.
- Undefined: fully combinational as above; clock and reset are unused.

Test Plan:
- 0x002081B3 (add x3,x1,x2), EX LSU_NONE → IFORMAT_R, ADD, raddr1=1, raddr2=2, waddr=3, wen=1, REG/REG, illegal=0, stall=0.
- 0x000280E7 (jalr x1,0(x5)) → IFORMAT_I, raddr1=5, waddr=1, wen=1, mux1 PC, mux2 IMM_FOUR, imm=0.
- 0x123452B7 (lui x5,0x12345) → IFORMAT_U, waddr=5, imm=0x0000000012345000, mux1 IMM_ZERO, mux2 IMM, wen=1.
- 0xFE208EE3 (beq x1,x2,-4) → IFORMAT_B, BEQ, wen=0, imm=0xFFFFFFFFFFFFFFFC, REG/REG.
- 0x00000000 → illegal=1, wen=0, IFORMAT_ILLEGAL.
- EX load, ex_wen=1, ex_rd=1, decoding 0x002081B3 → stall=1, wen=0. Same stimulus with ex_rd=0 → stall=0.
